// File: rtl/fixed_p_std_smult_arb.sv
// fixed_p_std_smult_arb
// Round-robin arbiter that shares one signed fixed-point multiplier among
// num_req requesters using a go/done handshake. The winner's operands are
// latched at grant. The product is formed in EXEC and truncated toward -inf
// to Q(int_width).(fract_width). The granted requester alone then sees a
// one-cycle done pulse in DONE.

module fixed_p_std_smult_arb #(
  parameter int width       = 32,
  parameter int int_width   = 8,
  parameter int fract_width = 24,
  parameter int num_req     = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [num_req-1:0]           go,
  input  logic [num_req*width-1:0]     left,
  input  logic [num_req*width-1:0]     right,
  output logic [width-1:0]             out,
  output logic [num_req-1:0]           done,
  output logic                         busy,
  output logic [$clog2(num_req)-1:0]   grant_id
);

  localparam int id_w = $clog2(num_req);
  // Bits of the full product that form the Q(int_width).(fract_width) result.
  localparam int res_lsb = fract_width;
  localparam int res_msb = int_width + 2 * fract_width - 1;

  localparam logic [1:0] st_idle = 2'd0;
  localparam logic [1:0] st_exec = 2'd1;
  localparam logic [1:0] st_done = 2'd2;

  localparam logic [id_w-1:0] last_idx = id_w'(num_req - 1);

  logic [1:0]                state_r;
  logic [id_w-1:0]           rr_ptr_r;
  logic [id_w-1:0]           grant_id_r;
  logic [width-1:0]          opa_r;
  logic [width-1:0]          opb_r;
  logic [width-1:0]          out_r;
  logic [num_req-1:0]        done_r;
  logic                      busy_r;

  logic [width-1:0]          left_a_s  [num_req];
  logic [width-1:0]          right_a_s [num_req];
  logic                      found_s;
  logic [id_w-1:0]           winner_s;
  logic [id_w-1:0]           rr_next_s;
  logic signed [2*width-1:0] opa_ext_s;
  logic signed [2*width-1:0] opb_ext_s;
  logic signed [2*width-1:0] prod_s;
  logic [num_req-1:0]        done_onehot_s;
  logic                      unused_s;

  // Unpack the flattened operand buses into per-requester slices.
  for (genvar g = 0; g < num_req; g++) begin : g_unpack
    assign left_a_s[g]  = left[g*width +: width];
    assign right_a_s[g] = right[g*width +: width];
  end

  // Round-robin search starting at rr_ptr, wrapping modulo num_req.
  always_comb begin
    logic [id_w:0] idx_v;
    found_s  = 1'b0;
    winner_s = '0;
    idx_v    = '0;
    for (int k = 0; k < num_req; k++) begin
      idx_v = {1'b0, rr_ptr_r} + (id_w+1)'(k);
      if (idx_v >= (id_w+1)'(num_req)) begin
        idx_v = idx_v - (id_w+1)'(num_req);
      end else begin
        idx_v = idx_v;
      end
      if (!found_s && go[idx_v[id_w-1:0]]) begin
        found_s  = 1'b1;
        winner_s = idx_v[id_w-1:0];
      end else begin
        found_s  = found_s;
        winner_s = winner_s;
      end
    end
  end

  // Pointer advances past the winner so that it has lowest priority next time.
  always_comb begin
    if (winner_s == last_idx) begin
      rr_next_s = '0;
    end else begin
      rr_next_s = winner_s + id_w'(1);
    end
  end

  // Signed full-width product of the latched operands, plus the done decode.
  always_comb begin
    opa_ext_s     = {{width{opa_r[width-1]}}, opa_r};
    opb_ext_s     = {{width{opb_r[width-1]}}, opb_r};
    prod_s        = opa_ext_s * opb_ext_s;
    done_onehot_s = {{(num_req-1){1'b0}}, 1'b1} << grant_id_r;
  end

  // Product bits that fall outside the truncated result are intentionally dropped.
  assign unused_s = ^{prod_s[2*width-1:res_msb+1], prod_s[res_lsb-1:0]};

  // Sequencer: IDLE grants, EXEC registers the product, DONE pulses done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= st_idle;
      rr_ptr_r   <= '0;
      grant_id_r <= '0;
      opa_r      <= '0;
      opb_r      <= '0;
      out_r      <= '0;
      done_r     <= '0;
      busy_r     <= 1'b0;
    end else begin
      case (state_r)
        st_idle: begin
          done_r <= '0;
          if (found_s) begin
            opa_r      <= left_a_s[winner_s];
            opb_r      <= right_a_s[winner_s];
            grant_id_r <= winner_s;
            rr_ptr_r   <= rr_next_s;
            busy_r     <= 1'b1;
            state_r    <= st_exec;
          end else begin
            busy_r  <= 1'b0;
            state_r <= st_idle;
          end
        end
        st_exec: begin
          out_r   <= prod_s[res_msb:res_lsb];
          done_r  <= done_onehot_s;
          busy_r  <= 1'b1;
          state_r <= st_done;
        end
        st_done: begin
          done_r  <= '0;
          busy_r  <= 1'b0;
          state_r <= st_idle;
        end
        default: begin
          done_r  <= '0;
          busy_r  <= 1'b0;
          state_r <= st_idle;
        end
      endcase
    end
  end

  assign out      = out_r;
  assign done     = done_r;
  assign busy     = busy_r;
  assign grant_id = grant_id_r;

endmodule

// File: tb/tb_fixed_p_std_smult_arb.sv
// Testbench for fixed_p_std_smult_arb: directed plan steps plus randomized
// request rounds checked against an arithmetic/round-robin reference model.

module tb_fixed_p_std_smult_arb;

  localparam int W   = 32;
  localparam int FW  = 24;
  localparam int N   = 4;
  localparam int IDW = 2;

  logic           clk;
  logic           reset;
  logic [N-1:0]   go;
  logic [N*W-1:0] left;
  logic [N*W-1:0] right;
  logic [W-1:0]   out;
  logic [N-1:0]   done;
  logic           busy;
  logic [IDW-1:0] grant_id;

  int total;
  int passed;
  int rr;

  fixed_p_std_smult_arb #(
    .width(W), .int_width(8), .fract_width(FW), .num_req(N)
  ) dut (
    .clk(clk), .reset(reset), .go(go), .left(left), .right(right),
    .out(out), .done(done), .busy(busy), .grant_id(grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference multiply: exact signed product, arithmetic shift, keep low W bits.
  function automatic logic [W-1:0] qmul(input logic [W-1:0] a, input logic [W-1:0] b);
    longint pa;
    longint pb;
    longint p;
    pa = longint'($signed(a));
    pb = longint'($signed(b));
    p  = (pa * pb) >>> FW;
    return p[W-1:0];
  endfunction

  // Reference arbiter: pending requester with the smallest distance from ptr.
  function automatic int pick(input logic [N-1:0] pend, input int ptr);
    int best;
    int bd;
    int d;
    best = -1;
    bd   = N;
    for (int i = 0; i < N; i++) begin
      if (pend[i]) begin
        d = (i - ptr + N) % N;
        if (d < bd) begin
          bd   = d;
          best = i;
        end
      end
    end
    return best;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed 0x%h, expected 0x%h", tag, obs, exp);
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    left[i*W +: W]  = a;
    right[i*W +: W] = b;
    go[i]           = 1'b1;
  endtask

  // Serve every pending request; optionally inject new ones while busy.
  task automatic service(input int max_adds);
    int w;
    int j;
    int added;
    logic [W-1:0] ex;
    added = 0;
    while (go != '0) begin
      w  = pick(go, rr);
      ex = qmul(left[w*W +: W], right[w*W +: W]);
      tick();
      check("busy_exec", busy, 1);
      check("done_exec", done, 0);
      tick();
      check("done_onehot", done, N'(1) << w);
      check("grant_id", grant_id, w);
      check("out", out, ex);
      check("busy_done", busy, 1);
      rr    = (w + 1) % N;
      go[w] = 1'b0;
      if (added < max_adds && $urandom_range(0, 1) == 1) begin
        j = $urandom_range(0, N - 1);
        if (j != w && !go[j]) begin
          set_req(j, $urandom, $urandom);
          added = added + 1;
        end
      end
      tick();
      check("done_clear", done, 0);
      check("busy_idle", busy, 0);
      check("out_hold", out, ex);
    end
  endtask

  initial begin
    logic [W-1:0] ex;
    logic [N-1:0] mask;
    total = 0;
    passed = 0;
    rr = 0;
    reset = 1'b1;
    go = '0;
    left = '0;
    right = '0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_out", out, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_grant", grant_id, 0);
    tick();
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);

    // Single request: 1.5 * -2.0 = -3.0
    set_req(0, 32'h0180_0000, 32'hFE00_0000);
    service(0);
    check("single_val", out, 32'hFD00_0000);
    check("single_gid", grant_id, 0);

    // Truncation toward -inf
    set_req(0, 32'h0000_0001, 32'hFF00_0000);
    service(0);
    check("trunc_neg", out, 32'hFFFF_FFFF);
    set_req(0, 32'h0000_0001, 32'h0080_0000);
    service(0);
    check("trunc_pos", out, 32'h0000_0000);

    // Fairness from a fresh pointer: all four, then 0 and 2
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rr = 0;
    for (int i = 0; i < N; i++) set_req(i, $urandom, $urandom);
    service(0);
    set_req(0, $urandom, $urandom);
    set_req(2, $urandom, $urandom);
    service(0);

    // Overflow wraps: 127.0 * 2.0
    set_req(2, 32'h7F00_0000, 32'h0200_0000);
    service(0);
    check("ovf_wrap", out, 32'hFE00_0000);

    // Operand change and go drop during EXEC: 0.75 * -0.75
    set_req(1, 32'h00C0_0000, 32'hFF40_0000);
    tick();
    check("chg_busy", busy, 1);
    left[1*W +: W]  = 32'h7FFF_FFFF;
    right[1*W +: W] = 32'h1234_5678;
    go[1] = 1'b0;
    tick();
    check("chg_done", done, 4'b0010);
    check("chg_out", out, 32'hFF70_0000);
    rr = 2;
    tick();
    check("chg_clear", done, 0);

    // Randomized rounds with injected requests
    repeat (15) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        if (mask[i]) set_req(i, $urandom, $urandom);
      end
      service(3);
    end

    // Reset during EXEC drops the operation
    set_req(1, 32'h0100_0000, 32'h0300_0000);
    tick();
    check("mid_busy", busy, 1);
    reset = 1'b1;
    go = '0;
    tick();
    reset = 1'b0;
    rr = 0;
    check("mid_done", done, 0);
    check("mid_out", out, 0);
    check("mid_busy0", busy, 0);
    check("mid_gid", grant_id, 0);
    tick();
    check("mid_nodone", done, 0);

    // Requester 3 alone after reset: 0.25 * 4.0 = 1.0
    set_req(3, 32'h0040_0000, 32'h0400_0000);
    ex = 32'h0100_0000;
    service(0);
    check("r3_out", out, ex);
    check("r3_gid", grant_id, 3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
